// File: rtl/reg_bc_alu_sequencer.sv
// reg_bc_alu_sequencer: settle/latch/release pulse sequencer for B/C loads and ALU ops.
// Ports: clk, rst_n, instr_valid/instr/instr_ready handshake; src_en/src_sel, load_b/load_c,
//   sel_bc/alu_func/alu_res_en, load_a/load_d/load_cc, done, err pulses.
// Optional: define RBC_OPCOUNT_EN to add op_count[15:0] (completed-instruction counter).
module reg_bc_alu_sequencer #(
  parameter int SETTLE = 2,
  parameter int N      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  output logic       src_en,
  output logic [2:0] src_sel,
  output logic       load_b,
  output logic       load_c,
  output logic       sel_bc,
  output logic [2:0] alu_func,
  output logic       alu_res_en,
  output logic       load_a,
  output logic       load_d,
  output logic       load_cc,
  output logic       done,
`ifdef RBC_OPCOUNT_EN
  output logic       err,
  output logic [15:0] op_count
`else
  output logic       err
`endif
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_LATCH  = 2'd2;
  localparam logic [1:0] S_REL    = 2'd3;

  if (SETTLE < 1 || N < 8) begin : g_bad_cfg
    $error("reg_bc_alu_sequencer: SETTLE must be >=1 and N >=8");
  end

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    ins_q, ins_d;

  logic       ready_q, ready_d;
  logic       src_en_q, src_en_d;
  logic [2:0] src_sel_q, src_sel_d;
  logic       load_b_q, load_b_d;
  logic       load_c_q, load_c_d;
  logic       sel_bc_q, sel_bc_d;
  logic [2:0] alu_func_q, alu_func_d;
  logic       alu_res_en_q, alu_res_en_d;
  logic       load_a_q, load_a_d;
  logic       load_d_q, load_d_d;
  logic       load_cc_q, load_cc_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic accept, is_alu_in, is_mov_in, legal_in;
  logic drive, is_alu, latch;

  always_comb begin
    accept    = instr_valid & ready_q;
    is_alu_in = (instr[7:4] == 4'b1000);
    is_mov_in = (instr[7:6] == 2'b00)
              && ((instr[5:3] == 3'b001) || (instr[5:3] == 3'b010))
              && (instr[5:3] != instr[2:0]);
    legal_in  = is_alu_in | is_mov_in;

    state_d = state_q;
    cnt_d   = cnt_q;
    ins_d   = ins_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && legal_in) begin
          state_d = S_SETTLE;
          cnt_d   = CW'(SETTLE - 1);
          ins_d   = instr;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_LATCH;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_LATCH: state_d = S_REL;
      default: state_d = S_IDLE;
    endcase

    // Outputs are computed from the next state so they come straight off flops.
    // A legal ALU op always has bit 7 set; a legal MOV8 never does.
    drive = (state_d != S_IDLE);
    is_alu = ins_d[7];
    latch  = (state_d == S_LATCH);

    ready_d      = (state_d == S_IDLE);
    src_en_d     = drive & ~is_alu;
    src_sel_d    = src_en_d ? ins_d[2:0] : 3'b000;
    load_b_d     = latch & ~is_alu & (ins_d[5:3] == 3'b001);
    load_c_d     = latch & ~is_alu & (ins_d[5:3] == 3'b010);
    sel_bc_d     = drive & is_alu;
    alu_func_d   = sel_bc_d ? ins_d[2:0] : 3'b000;
    alu_res_en_d = sel_bc_d;
    load_a_d     = latch & is_alu & ~ins_d[3];
    load_d_d     = latch & is_alu & ins_d[3];
    load_cc_d    = latch & is_alu;
    done_d       = (state_d == S_REL);
    err_d        = (state_q == S_IDLE) & accept & ~legal_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ins_q        <= '0;
      ready_q      <= 1'b0;
      src_en_q     <= 1'b0;
      src_sel_q    <= '0;
      load_b_q     <= 1'b0;
      load_c_q     <= 1'b0;
      sel_bc_q     <= 1'b0;
      alu_func_q   <= '0;
      alu_res_en_q <= 1'b0;
      load_a_q     <= 1'b0;
      load_d_q     <= 1'b0;
      load_cc_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ins_q        <= ins_d;
      ready_q      <= ready_d;
      src_en_q     <= src_en_d;
      src_sel_q    <= src_sel_d;
      load_b_q     <= load_b_d;
      load_c_q     <= load_c_d;
      sel_bc_q     <= sel_bc_d;
      alu_func_q   <= alu_func_d;
      alu_res_en_q <= alu_res_en_d;
      load_a_q     <= load_a_d;
      load_d_q     <= load_d_d;
      load_cc_q    <= load_cc_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign instr_ready = ready_q;
  assign src_en      = src_en_q;
  assign src_sel     = src_sel_q;
  assign load_b      = load_b_q;
  assign load_c      = load_c_q;
  assign sel_bc      = sel_bc_q;
  assign alu_func    = alu_func_q;
  assign alu_res_en  = alu_res_en_q;
  assign load_a      = load_a_q;
  assign load_d      = load_d_q;
  assign load_cc     = load_cc_q;
  assign done        = done_q;
  assign err         = err_q;

`ifdef RBC_OPCOUNT_EN
  logic [15:0] op_count_q, op_count_d;

  // Counts the cycle after each done pulse; wraps naturally at 16 bits.
  always_comb begin
    op_count_d = op_count_q;
    if (done_q) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count_q <= '0;
    else        op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`endif

endmodule
